seq_detector_101: RTL and testbench
===================================

Name: seq_detector_101

Overview:
- Serial "101" bit-pattern detector. Samples one input bit per rising clock edge.
- Produces two detect flags from two independent FSMs:
  - y_mealy: Mealy FSM; flags in the same cycle the final '1' is present on x.
  - y_moore: Moore FSM; flags one cycle later, decoded from state only.
- Sits at the head of a serial receive path as a pattern-match strobe source.

Parameters:
- OVERLAP, default 1: 1 = overlapping detection (the trailing '1' of a match can start the next match); 0 = non-overlapping (after a match, detection restarts from idle).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- x  input  1  serial data bit, sampled on rising clk
- y_mealy  output  1  Mealy detect flag, combinational from state and x
- y_moore  output  1  Moore detect flag, registered state decode

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous and active-low.
  - reset_n=0 forces both FSMs to idle immediately, independent of clk.
  - reset_n=0 overrides x, including when x is X or Z.
  - After reset_n rises, the first rising edge samples x.
- Reset values: y_mealy=0 and y_moore=0 while reset_n=0.
  - y_mealy is 0 in idle for any x, so X on x during reset never propagates.
- Mealy FSM states: M_IDLE, M_GOT1, M_GOT10.
  - M_IDLE: x=1 -> M_GOT1; x=0 -> M_IDLE.
  - M_GOT1: x=0 -> M_GOT10; x=1 -> M_GOT1.
  - M_GOT10: x=0 -> M_IDLE; x=1 -> M_GOT1 if OVERLAP=1, else M_IDLE.
  - Output: y_mealy = (state==M_GOT10) & x.
  - y_mealy is valid during the cycle the third bit is driven, before the edge that samples it. Latency 0 cycles.
- Moore FSM states: S_IDLE, S_GOT1, S_GOT10, S_DET.
  - S_IDLE, S_GOT1 and S_GOT10 transition as the Mealy equivalents, except S_GOT10 with x=1 -> S_DET.
  - S_DET: x=1 -> S_GOT1; x=0 -> S_GOT10 if OVERLAP=1, else S_IDLE.
  - Output: y_moore = (state==S_DET).
  - y_moore asserts for exactly one cycle per detection, one cycle after y_mealy's window.
- Both FSMs:
  - Use a plain registered state with next-state logic.
  - Illegal or unreachable encodings recover to idle on the next edge.
  - Reset mid-pattern discards all partial progress; both outputs drop to 0 asynchronously.
- Edge cases:
  - Input "11" keeps the Mealy FSM in GOT1 and the Moore FSM in S_GOT1 (no reset of progress).
  - Input "100" returns both FSMs to idle.

Decomposition:
- Package seq_detector_101_pkg holds the state enums (mealy_state_t, moore_state_t) and their encodings.
- Two natural sub-modules: mealy_fsm_101 and moore_fsm_101.
  - Each has ports clk, reset_n, x, y.
  - Each takes the OVERLAP parameter.
- The top only instantiates both sub-modules and wires them.

Test Plan:
- Reset and pre-reset state: x=X with reset_n=0 for 10 ns -> y_mealy=0, y_moore=0 throughout.
- Basic match, 10 ns clock with edges at 5, 15, 25, ...:
  - Release reset_n at 10 ns; drive x=0,0,1,0,1,0, changing every 10 ns from 10 ns.
  - y_mealy=1 only from 50 to 55 ns.
  - y_moore=1 only from 55 to 65 ns.
- Overlap with OVERLAP=1: x=1,0,1,0,1 -> y_mealy pulses twice (on bits 3 and 5); y_moore pulses twice, each one cycle after the matching y_mealy pulse.
- Non-overlap with OVERLAP=0: same x=1,0,1,0,1 -> exactly one detection on each output.
- Near-misses:
  - x=1,1,0,1 -> single detection on the final bit.
  - x=1,0,0,1 -> no detection.
- Mid-pattern reset: drive 1,0, pulse reset_n low asynchronously between edges, then drive 1 -> no detection; outputs fall immediately when reset_n falls.

Source files
------------

// File: rtl/seq_detector_101_pkg.sv
// Shared state encodings for the "101" serial pattern detectors.
package seq_detector_101_pkg;

  localparam int unsigned MEALY_STATE_W = 2;
  localparam int unsigned MOORE_STATE_W = 2;

  // Mealy detector: encoding 2'b11 is unreachable and recovers to idle.
  typedef enum logic [MEALY_STATE_W-1:0] {
    M_IDLE  = 2'd0,
    M_GOT1  = 2'd1,
    M_GOT10 = 2'd2
  } mealy_state_t;

  // Moore detector: S_DET is the one-cycle detect state.
  typedef enum logic [MOORE_STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_GOT1  = 2'd1,
    S_GOT10 = 2'd2,
    S_DET   = 2'd3
  } moore_state_t;

endpackage

// File: rtl/seq_detector_101_mealy.sv
// Mealy "101" detector: flags while the final '1' is on x, before it is sampled.
module mealy_fsm_101
  import seq_detector_101_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic x,
  output logic y
);

  mealy_state_t state_q, state_d;

  // State register; reset discards any partial match immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= M_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; the unused encoding falls back to idle.
  always_comb begin
    state_d = M_IDLE;
    case (state_q)
      M_IDLE:  state_d = x ? M_GOT1 : M_IDLE;
      M_GOT1:  state_d = x ? M_GOT1 : M_GOT10;
      M_GOT10: state_d = (x && OVERLAP) ? M_GOT1 : M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  // Idle gates x off, so an unknown x during reset never reaches y.
  assign y = (state_q == M_GOT10) && x;

endmodule

// File: rtl/seq_detector_101_moore.sv
// Moore "101" detector: flags for one cycle in S_DET, after the match is sampled.
module moore_fsm_101
  import seq_detector_101_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic x,
  output logic y
);

  moore_state_t state_q, state_d;

  // State register; reset discards any partial match immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; S_DET keeps the trailing "10" only when overlapping.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = x ? S_GOT1 : S_IDLE;
      S_GOT1:  state_d = x ? S_GOT1 : S_GOT10;
      S_GOT10: state_d = x ? S_DET  : S_IDLE;
      S_DET:   state_d = x ? S_GOT1 : (OVERLAP ? S_GOT10 : S_IDLE);
      default: state_d = S_IDLE;
    endcase
  end

  // Output decoded from the registered state only.
  assign y = (state_q == S_DET);

endmodule

// File: rtl/seq_detector_101.sv
// "101" pattern strobe source: Mealy (same-cycle) and Moore (next-cycle) flags.
module seq_detector_101
  import seq_detector_101_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic x,
  output logic y_mealy,
  output logic y_moore
);

  mealy_fsm_101 #(.OVERLAP(OVERLAP)) u_mealy (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (x),
    .y       (y_mealy)
  );

  moore_fsm_101 #(.OVERLAP(OVERLAP)) u_moore (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (x),
    .y       (y_moore)
  );

endmodule

// File: tb/tb_seq_detector_101.sv
// Directed bench for seq_detector_101, overlapping and non-overlapping instances.
module tb_seq_detector_101;

  logic clk;
  logic reset_n;
  logic x;
  logic ym_ov, yo_ov, ym_no, yo_no;

  int checks = 0;
  int errors = 0;

  seq_detector_101 #(.OVERLAP(1'b1)) dut_ov (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (x),
    .y_mealy (ym_ov),
    .y_moore (yo_ov)
  );

  seq_detector_101 #(.OVERLAP(1'b0)) dut_no (
    .clk     (clk),
    .reset_n (reset_n),
    .x       (x),
    .y_mealy (ym_no),
    .y_moore (yo_no)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk4(input string tag, input logic em1, input logic eo1,
                      input logic em0, input logic eo0);
    chk({tag, " mealy ov"}, ym_ov, em1);
    chk({tag, " moore ov"}, yo_ov, eo1);
    chk({tag, " mealy no"}, ym_no, em0);
    chk({tag, " moore no"}, yo_no, eo0);
  endtask

  // Drive one bit at a 10 ns boundary (falling clk), check 2 ns later.
  task automatic step(input string tag, input logic xb, input logic em1,
                      input logic eo1, input logic em0, input logic eo0);
    x = xb;
    #2;
    chk4(tag, em1, eo1, em0, eo0);
    #8;
  endtask

  // Hold reset across one rising edge, aligned to a 10 ns boundary.
  task automatic do_reset();
    reset_n = 1'b0;
    x = 1'b0;
    #10;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    x = 1'bx;
    #2;
    chk4("rst t2", 1'b0, 1'b0, 1'b0, 1'b0);
    #5;
    chk4("rst t7", 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    reset_n = 1'b1;

    // Basic match 0,0,1,0,1,0 from 10 ns
    step("b1", 1'b0, 0, 0, 0, 0);
    step("b2", 1'b0, 0, 0, 0, 0);
    step("b3", 1'b1, 0, 0, 0, 0);
    step("b4", 1'b0, 0, 0, 0, 0);
    x = 1'b1;                                  // t=50
    #2;  chk4("b5 t52", 1, 0, 1, 0);
    #5;  chk4("b5 t57", 0, 1, 0, 1);           // mealy window closed, moore up
    #3;
    x = 1'b0;                                  // t=60
    #2;  chk4("b6 t62", 0, 1, 0, 1);
    #5;  chk4("b6 t67", 0, 0, 0, 0);
    #3;

    // Overlap vs non-overlap: 1,0,1,0,1,0
    do_reset();
    step("o1", 1'b1, 0, 0, 0, 0);
    step("o2", 1'b0, 0, 0, 0, 0);
    step("o3", 1'b1, 1, 0, 1, 0);
    step("o4", 1'b0, 0, 1, 0, 1);
    step("o5", 1'b1, 1, 0, 0, 0);
    step("o6", 1'b0, 0, 1, 0, 0);

    // Near-miss 1,1,0,1,0: "11" keeps GOT1, single detection
    do_reset();
    step("n1", 1'b1, 0, 0, 0, 0);
    step("n2", 1'b1, 0, 0, 0, 0);
    step("n3", 1'b0, 0, 0, 0, 0);
    step("n4", 1'b1, 1, 0, 1, 0);
    step("n5", 1'b0, 0, 1, 0, 1);

    // Near-miss 1,0,0,1,0: "100" returns to idle
    do_reset();
    step("z1", 1'b1, 0, 0, 0, 0);
    step("z2", 1'b0, 0, 0, 0, 0);
    step("z3", 1'b0, 0, 0, 0, 0);
    step("z4", 1'b1, 0, 0, 0, 0);
    step("z5", 1'b0, 0, 0, 0, 0);

    // Mid-pattern reset: mealy drops asynchronously, progress discarded
    do_reset();
    step("r1", 1'b1, 0, 0, 0, 0);
    step("r2", 1'b0, 0, 0, 0, 0);
    x = 1'b1;
    #2;  chk4("r3 pre", 1, 0, 1, 0);
    #1;  reset_n = 1'b0;
    #1;  chk4("r3 async", 0, 0, 0, 0);
    #3;  reset_n = 1'b1;
    #3;
    step("r4", 1'b1, 0, 0, 0, 0);
    step("r5", 1'b0, 0, 0, 0, 0);
    step("r6", 1'b0, 0, 0, 0, 0);

    // Mid-detect reset: moore drops asynchronously
    do_reset();
    step("d1", 1'b1, 0, 0, 0, 0);
    step("d2", 1'b0, 0, 0, 0, 0);
    step("d3", 1'b1, 1, 0, 1, 0);
    x = 1'b0;
    #2;  chk4("d4 pre", 0, 1, 0, 1);
    #1;  reset_n = 1'b0;
    #1;  chk4("d4 async", 0, 0, 0, 0);
    #3;  reset_n = 1'b1;
    #3;
    step("d5", 1'b1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
